// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: data/address widths,
// the write-port controller state encoding and the writeback request record.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        RST  = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // One writeback request as presented by a requester (also used by the
    // core's writeback mux).
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the port that wins the
// next contended cycle; it moves to the loser only when update is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr;

    // Grant the lone requester, or the pointed-to port when both ask.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // After a contended grant, point at the port that lost (port 1 if port 0 won).
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (update) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owner of the register file write port: zero-sweeps x1..x(NREG-1) after
// reset, then shares the port between the execute and load writeback paths.
module rf_wb_arbiter #(
    parameter int XLEN       = rf_pkg::XLEN,
    parameter int AW         = rf_pkg::AW,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr0_valid,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_data,
    output logic            wr0_ready,
    input  logic            wr1_valid,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_data,
    output logic            wr1_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            init_busy
);

    import rf_pkg::*;

    localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic          run;
    logic          sweep;
    logic [1:0]    req;
    logic [1:0]    grant;
    logic          contended;
    logic          handshake;
    wr_req_t       sel;

    assign run       = (state == RUN);
    // The first edge after reset release already writes x1, so the sweep
    // step is active in RST as well as INIT.
    assign sweep     = INIT_CLEAR && (state == RST || state == INIT);
    assign req       = run ? {wr1_valid, wr0_valid} : 2'b00;
    assign contended = run && wr0_valid && wr1_valid;
    assign handshake = |grant;
    assign wr0_ready = grant[0];
    assign wr1_ready = grant[1];
    assign init_busy = !run;
    assign sel       = grant[1] ? '{addr: wr1_addr, data: wr1_data}
                                : '{addr: wr0_addr, data: wr0_data};

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (contended),
        .grant  (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave RST on release, finish the sweep on the last register.
    always_comb begin
        state_next = state;
        case (state)
            RST:     state_next = INIT_CLEAR ? ((cnt == LAST_REG) ? RUN : INIT) : RUN;
            INIT:    if (cnt == LAST_REG) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RST;
        endcase
    end

    // Sweep counter and registered write port; x0 writes are consumed silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= AW'(1);
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else if (sweep) begin
            rf_we    <= 1'b1;
            rf_addr  <= cnt;
            rf_wdata <= '0;
            cnt      <= cnt + AW'(1);
        end else if (handshake && sel.addr != '0) begin
            rf_we    <= 1'b1;
            rf_addr  <= sel.addr;
            rf_wdata <= sel.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: sweep, single-port writes, contention,
// x0 writes, mid-sweep reset, and an INIT_CLEAR=0 build in parallel.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr0_valid, wr1_valid;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        wr0_ready, wr1_ready;
    logic        rf_we, init_busy;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    logic        b_wr0_valid, b_wr1_valid;
    logic [4:0]  b_wr0_addr, b_wr1_addr;
    logic [31:0] b_wr0_data, b_wr1_data;
    logic        b_wr0_ready, b_wr1_ready;
    logic        b_rf_we, b_init_busy;
    logic [4:0]  b_rf_addr;
    logic [31:0] b_rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(32), .AW(5), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .init_busy(init_busy)
    );

    rf_wb_arbiter #(.XLEN(32), .AW(5), .INIT_CLEAR(1'b0)) dut_noclr (
        .clk(clk), .reset(reset),
        .wr0_valid(b_wr0_valid), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data), .wr0_ready(b_wr0_ready),
        .wr1_valid(b_wr1_valid), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data), .wr1_ready(b_wr1_ready),
        .rf_we(b_rf_we), .rf_addr(b_rf_addr), .rf_wdata(b_rf_wdata), .init_busy(b_init_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        wr0_valid = 1'b1; wr0_addr = 5'd9;  wr0_data = 32'h99;
        wr1_valid = 1'b1; wr1_addr = 5'd10; wr1_data = 32'hAA;
        b_wr0_valid = 1'b0; b_wr0_addr = 5'd0; b_wr0_data = 32'h0;
        b_wr1_valid = 1'b0; b_wr1_addr = 5'd0; b_wr1_data = 32'h0;

        // Reset for 3 cycles with both requesters asking.
        repeat (3) tick();
        check("rst_we",    rf_we, 0);
        check("rst_addr",  rf_addr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_busy",  init_busy, 1);
        check("rst_rdy0",  wr0_ready, 0);
        check("rst_rdy1",  wr1_ready, 0);
        check("b_rst_busy", b_init_busy, 1);

        // Release: sweep x1..x31; requests stay unanswered until the last step.
        reset = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check($sformatf("sweep_we_%0d", i),    rf_we, 1);
            check($sformatf("sweep_addr_%0d", i),  rf_addr, i);
            check($sformatf("sweep_wdata_%0d", i), rf_wdata, 0);
            check($sformatf("sweep_busy_%0d", i),  init_busy, (i == 31) ? 0 : 1);
            if (i < 31) begin
                check($sformatf("sweep_rdy0_%0d", i), wr0_ready, 0);
                check($sformatf("sweep_rdy1_%0d", i), wr1_ready, 0);
            end
            if (i == 30) begin
                wr0_valid = 1'b0;
                wr1_valid = 1'b0;
            end
            // The no-clear build is in RUN right after release.
            if (i == 1) begin
                check("b_busy", b_init_busy, 0);
                check("b_we0",  b_rf_we, 0);
                b_wr0_valid = 1'b1; b_wr0_addr = 5'd2; b_wr0_data = 32'h0000ABCD;
                #1;
                check("b_rdy0", b_wr0_ready, 1);
            end
            if (i == 2) begin
                b_wr0_valid = 1'b0;
                check("b_we",    b_rf_we, 1);
                check("b_addr",  b_rf_addr, 2);
                check("b_wdata", b_rf_wdata, 32'h0000ABCD);
            end
        end

        // Single request on port 0.
        wr0_valid = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        #1;
        check("p0_rdy0", wr0_ready, 1);
        check("p0_rdy1", wr1_ready, 0);
        tick();
        wr0_valid = 1'b0;
        check("p0_we",    rf_we, 1);
        check("p0_addr",  rf_addr, 5);
        check("p0_wdata", rf_wdata, 32'hDEADBEEF);

        // Idle cycle: no write, address/data hold.
        tick();
        check("idle_we",    rf_we, 0);
        check("idle_addr",  rf_addr, 5);
        check("idle_wdata", rf_wdata, 32'hDEADBEEF);

        // Both valid for 4 cycles: grants alternate 0,1,0,1.
        wr0_valid = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11;
        wr1_valid = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_rdy0_%0d", k), wr0_ready, (k % 2 == 0) ? 1 : 0);
            check($sformatf("rr_rdy1_%0d", k), wr1_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            check($sformatf("rr_we_%0d", k),    rf_we, 1);
            check($sformatf("rr_addr_%0d", k),  rf_addr, (k % 2 == 0) ? 3 : 4);
            check($sformatf("rr_wdata_%0d", k), rf_wdata, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;

        // Port 1 writes x0: consumed, no register-file write.
        wr1_valid = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        #1;
        check("x0_rdy1", wr1_ready, 1);
        tick();
        wr1_valid = 1'b0;
        check("x0_we", rf_we, 0);

        // Uncontended port 1 grant leaves the pointer on port 0.
        wr1_valid = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h77;
        #1;
        check("u1_rdy1", wr1_ready, 1);
        tick();
        check("u1_addr", rf_addr, 7);
        wr0_valid = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h88;
        wr1_valid = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        #1;
        check("ptr_rdy0", wr0_ready, 1);
        check("ptr_rdy1", wr1_ready, 0);
        tick();
        check("ptr_addr", rf_addr, 8);
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;

        // Reset mid-sweep at address 12, then a full restart.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) tick();
        check("mid_addr12", rf_addr, 12);
        reset = 1'b0;
        tick();
        check("mid_rst_we",   rf_we, 0);
        check("mid_rst_addr", rf_addr, 0);
        check("mid_rst_busy", init_busy, 1);
        reset = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            check($sformatf("resweep_we_%0d", i),   rf_we, 1);
            check($sformatf("resweep_addr_%0d", i), rf_addr, i);
            check($sformatf("resweep_busy_%0d", i), init_busy, (i == 31) ? 0 : 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
